// File: rtl/video_pkg.sv
// -----------------------------------------------------------------------------
// video_pkg
// Shared constants and helpers for the VGA raster timing block.
//   - Default 640x480@60 timing values (pixels / lines)
//   - SYNC_POL encodings (active-low / active-high)
//   - counter_width(): width of a signed counter able to span -blank..active-1
// No ports (package).
// -----------------------------------------------------------------------------
package video_pkg;

   // Default horizontal timing (pixels)
   localparam int DEF_HACTIVE = 640;
   localparam int DEF_HFRONT  = 16;
   localparam int DEF_HSYNC   = 96;
   localparam int DEF_HBACK   = 48;

   // Default vertical timing (lines)
   localparam int DEF_VACTIVE = 480;
   localparam int DEF_VFRONT  = 10;
   localparam int DEF_VSYNC   = 2;
   localparam int DEF_VBACK   = 33;

   // Sync polarity encodings
   localparam int SYNC_POL_LOW  = 0;
   localparam int SYNC_POL_HIGH = 1;

   // A signed counter covering a full period of 'total' needs one bit more than
   // the unsigned count, so both -blank and active-1 fit.
   function automatic int counter_width(input int total);
      return $clog2(total) + 1;
   endfunction

endpackage

// File: rtl/timing_axis.sv
// -----------------------------------------------------------------------------
// timing_axis
// One raster axis (horizontal or vertical): a signed position counter running
// -(FRONT+SYNC+BACK) .. ACTIVE-1, advancing when 'step' is high, plus a
// registered sync decode aligned with the counter.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset (counter -> first porch value)
//   step       in   advance the counter this cycle
//   count      out  registered signed position
//   count_next out  value count will take on the next edge (for aligned decodes)
//   wrap       out  high when this cycle's step wraps the counter
//   sync       out  registered sync, polarity per SYNC_POL
// -----------------------------------------------------------------------------
module timing_axis
   import video_pkg::*;
#(
   parameter int ACTIVE   = DEF_HACTIVE,
   parameter int FRONT    = DEF_HFRONT,
   parameter int SYNC     = DEF_HSYNC,
   parameter int BACK     = DEF_HBACK,
   parameter int SYNC_POL = SYNC_POL_LOW,
   parameter int WIDTH    = counter_width(ACTIVE + FRONT + SYNC + BACK)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    step,
   output logic signed [WIDTH-1:0] count,
   output logic signed [WIDTH-1:0] count_next,
   output logic                    wrap,
   output logic                    sync
);

   localparam int BLANK = FRONT + SYNC + BACK;

   localparam logic signed [WIDTH-1:0] FIRST      = WIDTH'(-BLANK);
   localparam logic signed [WIDTH-1:0] LAST       = WIDTH'(ACTIVE - 1);
   localparam logic signed [WIDTH-1:0] SYNC_FIRST = WIDTH'(-(SYNC + BACK));
   localparam logic signed [WIDTH-1:0] SYNC_LAST  = WIDTH'(-BACK - 1);

   localparam logic SYNC_ON       = (SYNC_POL == SYNC_POL_HIGH);
   // The first porch position is inside the sync window only with no front porch.
   localparam logic SYNC_AT_FIRST = (FRONT == 0) ? SYNC_ON : !SYNC_ON;

   logic signed [WIDTH-1:0] count_reg;
   logic                    sync_reg;
   logic                    sync_next;

   always_comb begin
      wrap       = step && (count_reg == LAST);
      count_next = count_reg;
      if (wrap) begin
         count_next = FIRST;
      end else if (step) begin
         count_next = count_reg + WIDTH'(1);
      end
      // Decode from the next value so the registered sync lines up with count.
      if ((count_next >= SYNC_FIRST) && (count_next <= SYNC_LAST)) begin
         sync_next = SYNC_ON;
      end else begin
         sync_next = !SYNC_ON;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= FIRST;
         sync_reg  <= SYNC_AT_FIRST;
      end else begin
         count_reg <= count_next;
         sync_reg  <= sync_next;
      end
   end

   assign count = count_reg;
   assign sync  = sync_reg;

endmodule

// File: rtl/video_timing.sv
// -----------------------------------------------------------------------------
// video_timing
// VGA raster generator: signed H/V position counters (active region is where
// both are non-negative), sync, blanking, line/frame pulses, and a frame-based
// animation time with a power-of-two frame prescaler.
// Ports:
//   clk          in   pixel clock
//   reset        in   synchronous active-high reset
//   time_enable  in   allow cur_time to advance
//   time_div     in   advance cur_time once every 2^time_div frames
//   counter_h    out  signed horizontal position, -HBLANK..HACTIVE-1
//   counter_v    out  signed vertical position, -VBLANK..VACTIVE-1
//   hsync/vsync  out  sync outputs, polarity per SYNC_POL
//   blank        out  high when either counter is negative
//   new_line     out  pulse at counter_h == -HBLANK
//   new_frame    out  pulse at the first pixel of a frame
//   cur_time     out  8-bit animation time
// All outputs are registered and aligned with the counters.
// -----------------------------------------------------------------------------
module video_timing
   import video_pkg::*;
#(
   parameter int HACTIVE  = DEF_HACTIVE,
   parameter int HFRONT   = DEF_HFRONT,
   parameter int HSYNC    = DEF_HSYNC,
   parameter int HBACK    = DEF_HBACK,
   parameter int VACTIVE  = DEF_VACTIVE,
   parameter int VFRONT   = DEF_VFRONT,
   parameter int VSYNC    = DEF_VSYNC,
   parameter int VBACK    = DEF_VBACK,
   parameter int SYNC_POL = SYNC_POL_LOW,
   localparam int HTOTAL  = HACTIVE + HFRONT + HSYNC + HBACK,
   localparam int VTOTAL  = VACTIVE + VFRONT + VSYNC + VBACK,
   localparam int HBLANK  = HTOTAL - HACTIVE,
   localparam int VBLANK  = VTOTAL - VACTIVE,
   localparam int HW      = counter_width(HTOTAL),
   localparam int VW      = counter_width(VTOTAL)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 time_enable,
   input  logic [1:0]           time_div,
   output logic signed [HW-1:0] counter_h,
   output logic signed [VW-1:0] counter_v,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 blank,
   output logic                 new_line,
   output logic                 new_frame,
   output logic [7:0]           cur_time
);

   localparam logic signed [HW-1:0] H_FIRST = HW'(-HBLANK);
   localparam logic signed [VW-1:0] V_FIRST = VW'(-VBLANK);

   logic signed [HW-1:0] h_next;
   logic signed [VW-1:0] v_next;
   logic                 h_wrap;
   logic                 v_wrap;
   logic                 frame_wrap;

   logic                 blank_reg;
   logic                 new_line_reg;
   logic                 new_frame_reg;
   logic [7:0]           cur_time_reg;
   logic [7:0]           cur_time_next;
   logic [2:0]           presc_reg;
   logic [2:0]           presc_next;
   logic [2:0]           presc_limit;

   timing_axis #(
      .ACTIVE   (HACTIVE),
      .FRONT    (HFRONT),
      .SYNC     (HSYNC),
      .BACK     (HBACK),
      .SYNC_POL (SYNC_POL),
      .WIDTH    (HW)
   ) u_h_axis (
      .clk        (clk),
      .reset      (reset),
      .step       (1'b1),
      .count      (counter_h),
      .count_next (h_next),
      .wrap       (h_wrap),
      .sync       (hsync)
   );

   // The vertical axis advances once per line, on the horizontal wrap.
   timing_axis #(
      .ACTIVE   (VACTIVE),
      .FRONT    (VFRONT),
      .SYNC     (VSYNC),
      .BACK     (VBACK),
      .SYNC_POL (SYNC_POL),
      .WIDTH    (VW)
   ) u_v_axis (
      .clk        (clk),
      .reset      (reset),
      .step       (h_wrap),
      .count      (counter_v),
      .count_next (v_next),
      .wrap       (v_wrap),
      .sync       (vsync)
   );

   // v_wrap already implies h_wrap, but keep the intent explicit.
   assign frame_wrap = h_wrap && v_wrap;

   always_comb begin
      // 2^time_div - 1; computed in 4 bits so time_div = 3 yields 7.
      presc_limit   = 3'((4'd1 << time_div) - 4'd1);
      cur_time_next = cur_time_reg;
      presc_next    = presc_reg;
      if (frame_wrap && time_enable) begin
         if (presc_reg >= presc_limit) begin
            cur_time_next = cur_time_reg + 8'd1;
            presc_next    = 3'd0;
         end else begin
            presc_next = presc_reg + 3'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         blank_reg     <= 1'b1;
         new_line_reg  <= 1'b1;
         new_frame_reg <= 1'b1;
         cur_time_reg  <= 8'd0;
         presc_reg     <= 3'd0;
      end else begin
         // Decoded from the next counter values so they align with the counters.
         blank_reg     <= h_next[HW-1] | v_next[VW-1];
         new_line_reg  <= (h_next == H_FIRST);
         new_frame_reg <= (h_next == H_FIRST) && (v_next == V_FIRST);
         cur_time_reg  <= cur_time_next;
         presc_reg     <= presc_next;
      end
   end

   assign blank     = blank_reg;
   assign new_line  = new_line_reg;
   assign new_frame = new_frame_reg;
   assign cur_time  = cur_time_reg;

endmodule

// File: tb/tb_video_timing.sv
// -----------------------------------------------------------------------------
// tb_video_timing
// Directed bench for video_timing: a default 640x480 instance for line and
// frame sync timing, and a tiny 4x2 instance (1/1/1 porches, 7x5 total) for
// exact counter sequences, periods and the animation-time prescaler.
// -----------------------------------------------------------------------------
module tb_video_timing;

   logic clk;
   logic reset;

   // default instance
   logic              time_enable;
   logic [1:0]        time_div;
   logic signed [10:0] counter_h;
   logic signed [10:0] counter_v;
   logic              hsync, vsync, blank, new_line, new_frame;
   logic [7:0]        cur_time;

   // small instance
   logic              time_enable_s;
   logic [1:0]        time_div_s;
   logic signed [3:0] counter_h_s;
   logic signed [3:0] counter_v_s;
   logic              hsync_s, vsync_s, blank_s, new_line_s, new_frame_s;
   logic [7:0]        cur_time_s;

   int tests_run    = 0;
   int tests_failed = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   video_timing dut (
      .clk         (clk),
      .reset       (reset),
      .time_enable (time_enable),
      .time_div    (time_div),
      .counter_h   (counter_h),
      .counter_v   (counter_v),
      .hsync       (hsync),
      .vsync       (vsync),
      .blank       (blank),
      .new_line    (new_line),
      .new_frame   (new_frame),
      .cur_time    (cur_time)
   );

   video_timing #(
      .HACTIVE (4), .HFRONT (1), .HSYNC (1), .HBACK (1),
      .VACTIVE (2), .VFRONT (1), .VSYNC (1), .VBACK (1),
      .SYNC_POL (0)
   ) dut_s (
      .clk         (clk),
      .reset       (reset),
      .time_enable (time_enable_s),
      .time_div    (time_div_s),
      .counter_h   (counter_h_s),
      .counter_v   (counter_v_s),
      .hsync       (hsync_s),
      .vsync       (vsync_s),
      .blank       (blank_s),
      .new_line    (new_line_s),
      .new_frame   (new_frame_s),
      .cur_time    (cur_time_s)
   );

   task automatic do_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      time_enable_s = 1'b1;
      time_div_s    = 2'd0;
      repeat (300) @(negedge clk);  // mid-line, small cur_time has advanced
      do_reset();
      time_enable_s = 1'b0;
      tests_run++; if (counter_h !== -11'sd160) begin tests_failed++; $display("FAIL reset_counter_h: got %0d expected -160", counter_h); end
      tests_run++; if (counter_v !== -11'sd45) begin tests_failed++; $display("FAIL reset_counter_v: got %0d expected -45", counter_v); end
      tests_run++; if (blank !== 1'b1) begin tests_failed++; $display("FAIL reset_blank: got %b expected 1", blank); end
      tests_run++; if (new_line !== 1'b1) begin tests_failed++; $display("FAIL reset_new_line: got %b expected 1", new_line); end
      tests_run++; if (new_frame !== 1'b1) begin tests_failed++; $display("FAIL reset_new_frame: got %b expected 1", new_frame); end
      tests_run++; if (hsync !== 1'b1 || vsync !== 1'b1) begin tests_failed++; $display("FAIL reset_syncs: got %b%b expected 11", hsync, vsync); end
      tests_run++; if (cur_time !== 8'd0) begin tests_failed++; $display("FAIL reset_cur_time: got %0d expected 0", cur_time); end
      tests_run++; if (counter_h_s !== -4'sd3 || counter_v_s !== -4'sd3) begin tests_failed++; $display("FAIL reset_small_counters: got %0d,%0d expected -3,-3", counter_h_s, counter_v_s); end
      tests_run++; if (cur_time_s !== 8'd0) begin tests_failed++; $display("FAIL reset_small_cur_time: got %0d expected 0", cur_time_s); end
      $display("[TB] reset: h=%0d v=%0d blank=%b new_frame=%b cur_time_s=%0d", counter_h, counter_v, blank, new_frame, cur_time_s);
   endtask

   // Starts at the first pixel of a frame (h=-160).
   task automatic test_line_timing();
      int low_cnt   = 0;
      int first_low = -1;
      int h_at_low  = 9999;
      int period    = -1;
      for (int i = 0; i <= 800; i++) begin
         if (hsync == 1'b0) begin
            if (low_cnt == 0) begin first_low = i; h_at_low = int'(counter_h); end
            low_cnt++;
         end
         if (i > 0 && new_line == 1'b1 && period < 0) period = i;
         @(negedge clk);
      end
      tests_run++; if (first_low !== 16 || h_at_low !== -144) begin tests_failed++; $display("FAIL hsync_start: got idx %0d h %0d expected idx 16 h -144", first_low, h_at_low); end
      tests_run++; if (low_cnt !== 96) begin tests_failed++; $display("FAIL hsync_width: got %0d expected 96", low_cnt); end
      tests_run++; if (period !== 800) begin tests_failed++; $display("FAIL line_period: got %0d expected 800", period); end
      $display("[TB] line: hsync start h=%0d width=%0d period=%0d", h_at_low, low_cnt, period);
   endtask

   // Runs the default instance through vertical blanking into the first active pixel.
   task automatic test_frame_timing();
      int   vs_low = 0;
      int   vs_v   = 9999;
      int   vs_h   = 9999;
      int   fall_h = 9999;
      int   fall_v = 9999;
      bit   found  = 1'b0;
      logic prev_blank;
      prev_blank = blank;
      for (int i = 0; i < 40000 && !found; i++) begin
         @(negedge clk);
         if (vsync == 1'b0) begin
            if (vs_low == 0) begin vs_v = int'(counter_v); vs_h = int'(counter_h); end
            vs_low++;
         end
         if (prev_blank == 1'b1 && blank == 1'b0) begin
            found  = 1'b1;
            fall_h = int'(counter_h);
            fall_v = int'(counter_v);
         end
         prev_blank = blank;
      end
      tests_run++; if (!found) begin tests_failed++; $display("FAIL blank_fall_timeout: got none expected fall within 40000 cycles"); end
      tests_run++; if (fall_h !== 0 || fall_v !== 0) begin tests_failed++; $display("FAIL blank_fall_pos: got h %0d v %0d expected 0 0", fall_h, fall_v); end
      tests_run++; if (vs_low !== 1600) begin tests_failed++; $display("FAIL vsync_width: got %0d expected 1600", vs_low); end
      tests_run++; if (vs_v !== -35 || vs_h !== -160) begin tests_failed++; $display("FAIL vsync_start: got v %0d h %0d expected -35 -160", vs_v, vs_h); end
      $display("[TB] frame: vsync start v=%0d width=%0d blank falls at h=%0d v=%0d", vs_v, vs_low, fall_h, fall_v);
   endtask

   // Exact small-instance sequence over two frames, including the H/V double wrap.
   task automatic test_small_sequence();
      int   htab [7] = '{-3, -2, -1, 0, 1, 2, 3};
      int   vtab [5] = '{-3, -2, -1, 0, 1};
      int   exp_h, exp_v;
      logic exp_b;
      int   errs_before;
      errs_before = tests_failed;
      do_reset();
      for (int i = 0; i < 70; i++) begin
         exp_h = htab[i % 7];
         exp_v = vtab[(i / 7) % 5];
         exp_b = (exp_h < 0) || (exp_v < 0);
         tests_run++; if (counter_h_s !== 4'(exp_h)) begin tests_failed++; $display("FAIL seq_h[%0d]: got %0d expected %0d", i, counter_h_s, exp_h); end
         tests_run++; if (counter_v_s !== 4'(exp_v)) begin tests_failed++; $display("FAIL seq_v[%0d]: got %0d expected %0d", i, counter_v_s, exp_v); end
         tests_run++; if (hsync_s !== ((exp_h == -2) ? 1'b0 : 1'b1)) begin tests_failed++; $display("FAIL seq_hsync[%0d]: got %b at h %0d", i, hsync_s, exp_h); end
         tests_run++; if (vsync_s !== ((exp_v == -2) ? 1'b0 : 1'b1)) begin tests_failed++; $display("FAIL seq_vsync[%0d]: got %b at v %0d", i, vsync_s, exp_v); end
         tests_run++; if (blank_s !== exp_b) begin tests_failed++; $display("FAIL seq_blank[%0d]: got %b expected %b", i, blank_s, exp_b); end
         tests_run++; if (new_line_s !== (exp_h == -3)) begin tests_failed++; $display("FAIL seq_new_line[%0d]: got %b expected %b", i, new_line_s, (exp_h == -3)); end
         tests_run++; if (new_frame_s !== ((i % 35) == 0)) begin tests_failed++; $display("FAIL seq_new_frame[%0d]: got %b expected %b", i, new_frame_s, ((i % 35) == 0)); end
         @(negedge clk);
      end
      $display("[TB] small sequence: 70 cycles checked, %0d failed", tests_failed - errs_before);
   endtask

   task automatic test_small_periods();
      int line_p  = -1;
      int frame_p = -1;
      do_reset();
      for (int j = 1; j <= 100 && line_p < 0; j++) begin
         @(negedge clk);
         if (new_line_s == 1'b1) line_p = j;
      end
      do_reset();
      for (int j = 1; j <= 100 && frame_p < 0; j++) begin
         @(negedge clk);
         if (new_frame_s == 1'b1) frame_p = j;
      end
      tests_run++; if (line_p !== 7) begin tests_failed++; $display("FAIL small_line_period: got %0d expected 7", line_p); end
      tests_run++; if (frame_p !== 35) begin tests_failed++; $display("FAIL small_frame_period: got %0d expected 35", frame_p); end
      $display("[TB] small periods: line=%0d frame=%0d", line_p, frame_p);
   endtask

   task automatic test_time_divider();
      do_reset();
      time_enable_s = 1'b1;
      time_div_s    = 2'd2;
      repeat (3 * 35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd0) begin tests_failed++; $display("FAIL div2_3frames: got %0d expected 0", cur_time_s); end
      repeat (35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd1) begin tests_failed++; $display("FAIL div2_4frames: got %0d expected 1", cur_time_s); end
      tests_run++; if (new_frame_s !== 1'b1) begin tests_failed++; $display("FAIL div2_frame_align: got %b expected 1", new_frame_s); end
      repeat (3 * 35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd1) begin tests_failed++; $display("FAIL div2_7frames: got %0d expected 1", cur_time_s); end
      repeat (35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd2) begin tests_failed++; $display("FAIL div2_8frames: got %0d expected 2", cur_time_s); end
      time_div_s = 2'd0;
      repeat (35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd3) begin tests_failed++; $display("FAIL div0_frame1: got %0d expected 3", cur_time_s); end
      repeat (35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd4) begin tests_failed++; $display("FAIL div0_frame2: got %0d expected 4", cur_time_s); end
      // Lower time_div mid-count: presc=1 already satisfies limit 0.
      time_div_s = 2'd2;
      repeat (35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd4) begin tests_failed++; $display("FAIL div_lower_prep: got %0d expected 4", cur_time_s); end
      time_div_s = 2'd0;
      repeat (35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd5) begin tests_failed++; $display("FAIL div_lower_incr: got %0d expected 5", cur_time_s); end
      $display("[TB] time divider: cur_time_s=%0d", cur_time_s);
   endtask

   task automatic test_wrap_freeze();
      do_reset();
      time_enable_s = 1'b1;
      time_div_s    = 2'd0;
      repeat (255 * 35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd255) begin tests_failed++; $display("FAIL time_255: got %0d expected 255", cur_time_s); end
      repeat (35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd0) begin tests_failed++; $display("FAIL time_wrap: got %0d expected 0", cur_time_s); end
      time_enable_s = 1'b0;
      repeat (3 * 35 + 2) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd0) begin tests_failed++; $display("FAIL freeze_hold: got %0d expected 0", cur_time_s); end
      tests_run++; if (counter_h_s !== -4'sd1 || counter_v_s !== -4'sd3) begin tests_failed++; $display("FAIL freeze_counters_run: got %0d,%0d expected -1,-3", counter_h_s, counter_v_s); end
      repeat (33) @(negedge clk);
      time_enable_s = 1'b1;
      repeat (35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd1) begin tests_failed++; $display("FAIL unfreeze_incr: got %0d expected 1", cur_time_s); end
      // Prescaler must also hold while disabled.
      time_div_s = 2'd1;
      repeat (35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd1) begin tests_failed++; $display("FAIL presc_half: got %0d expected 1", cur_time_s); end
      time_enable_s = 1'b0;
      repeat (3 * 35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd1) begin tests_failed++; $display("FAIL presc_freeze_hold: got %0d expected 1", cur_time_s); end
      time_enable_s = 1'b1;
      repeat (35) @(negedge clk);
      tests_run++; if (cur_time_s !== 8'd2) begin tests_failed++; $display("FAIL presc_resume: got %0d expected 2", cur_time_s); end
      $display("[TB] wrap/freeze: cur_time_s=%0d", cur_time_s);
   endtask

   initial begin
      reset         = 1'b1;
      time_enable   = 1'b0;
      time_div      = 2'd0;
      time_enable_s = 1'b0;
      time_div_s    = 2'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      test_reset();
      test_line_timing();
      test_frame_timing();
      test_small_sequence();
      test_small_periods();
      test_time_divider();
      test_wrap_freeze();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/video_timing.md
# video_timing

Generates the raster position, sync and blanking for the VGA output and the frame-based animation time. Drives the signed `counter_h`/`counter_v` and 8-bit `cur_time` buses that the background, sprite and pixel-mux logic consume. The active region is exactly where both counters are non-negative, so downstream blocks index pixels directly from the counters.

## Interface
- `HACTIVE`, 640, visible pixels per line
- `HFRONT`, 16, horizontal front porch (pixels)
- `HSYNC`, 96, horizontal sync width (pixels)
- `HBACK`, 48, horizontal back porch (pixels)
- `VACTIVE`, 480, visible lines per frame
- `VFRONT`, 10, vertical front porch (lines)
- `VSYNC`, 2, vertical sync width (lines)
- `VBACK`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, sync polarity: 0 = active-low, 1 = active-high
- Derived: `HTOTAL` = sum of the H values (800); `VTOTAL` = sum of the V values (525); `HBLANK = HTOTAL-HACTIVE`; `VBLANK = VTOTAL-VACTIVE`

- `clk`  in  1  pixel clock
- `reset`  in  1  synchronous, active-high reset
- `time_enable`  in  1  allow `cur_time` to advance
- `time_div`  in  2  advance `cur_time` once every 2^`time_div` frames
- `counter_h`  out  signed $clog2(HTOTAL)+1  horizontal position, -HBLANK..HACTIVE-1
- `counter_v`  out  signed $clog2(VTOTAL)+1  vertical position, -VBLANK..VACTIVE-1
- `hsync`  out  1  horizontal sync, polarity per `SYNC_POL`
- `vsync`  out  1  vertical sync, polarity per `SYNC_POL`
- `blank`  out  1  high when either counter is negative
- `new_line`  out  1  one-cycle pulse while `counter_h == -HBLANK`
- `new_frame`  out  1  one-cycle pulse while `counter_h == -HBLANK && counter_v == -VBLANK`
- `cur_time`  out  8  animation time

## Operation
- Line order: front porch, sync, back porch, active. With defaults, H: front -160..-145, sync -144..-49, back -48..-1, active 0..639.
- V with defaults: front -45..-36, sync -35..-34, back -33..-1, active 0..479.
- `counter_h` increments every cycle. At `HACTIVE-1` it wraps to `-HBLANK`, and on that same edge `counter_v` increments.
- `counter_v` wraps from `VACTIVE-1` to `-VBLANK` on the edge where `counter_h` also wraps.
- `hsync` is asserted iff `counter_h` is in [-(HSYNC+HBACK), -HBACK-1].
- `vsync` is asserted iff `counter_v` is in [-(VSYNC+VBACK), -VBACK-1], for whole lines and independent of `counter_h`.
- Prescaler: 3-bit frame counter `presc`, reset 0. At each frame wrap (end of the last active pixel):
  - if `time_enable` = 0: no change to `cur_time` or `presc`;
  - else if `presc >= 2^time_div - 1`: `cur_time` += 1 (mod 256, wraps 255 to 0) and `presc` is set to 0;
  - else `presc` += 1.
- `time_div` is sampled at the wrap edge only. Lowering it mid-count causes an increment at the next wrap.
- `time_enable` low freezes `cur_time` and `presc`. Counters and syncs keep running.

## Timing
- Every output is a register. Its value in cycle n reflects counter state n; sync, blank and pulses carry no extra latency relative to the counters.
- Reset values (after a synchronous `reset` edge):
  - `counter_h = -HBLANK`, `counter_v = -VBLANK`
  - `blank = 1`, `hsync`/`vsync` inactive
  - `new_line = 1`, `new_frame = 1`
  - `cur_time = 0`, `presc = 0`
- Reset asserted mid-frame overrides everything on that edge. The first post-reset cycle is the first pixel of a new frame.
- Frame period is exactly `HTOTAL*VTOTAL` cycles (420000 with defaults); line period is exactly `HTOTAL`.
- Arithmetic: counters are two's complement. Comparisons are signed against sign-extended parameter constants. No counter value outside the stated range ever appears.

## Structure
- The shared package `video_pkg` holds:
  - the default 640x480 timing constants;
  - a function computing counter width from a total;
  - `SYNC_POL` encoding constants.
- One sub-module, `timing_axis`, is instantiated twice (H and V). It contains:
  - a parameterized signed counter with a `step` input;
  - wrap output;
  - sync-window decode.
- H uses `step = 1`. V uses `step` = the H wrap output.
- The prescaler and `cur_time` live in the top module.

## Test plan
- **Reset:** assert `reset` for 3 cycles mid-line. Next cycle must show `counter_h = -160`, `counter_v = -45`, `blank = 1`, `new_frame = 1`, `cur_time = 0`.
- **Line timing (defaults, active-low):**
  - `hsync` is low for exactly 96 cycles starting at `counter_h = -144`;
  - `blank` falls at `counter_h = 0`;
  - the line period measures exactly 800 cycles.
- **Frame timing:**
  - `vsync` is low for exactly 1600 cycles (2 lines) starting at `counter_v = -35`;
  - `new_frame` pulses every 420000 cycles.
- **Time divider:**
  - `time_enable = 1`, `time_div = 2`: `cur_time` goes 0 → 1 after 4 frames, then 2 after 8 frames;
  - `time_div = 0`: one increment per frame.
- **Wrap and freeze:**
  - preload toward 255 by running 256 frames at `time_div = 0`; `cur_time` wraps 255 → 0;
  - dropping `time_enable` holds `cur_time` constant across 3 frames while counters continue.
- **Small parameter set** (`HACTIVE = 4`, porches 1/1/1, `VACTIVE = 2`, porches 1/1/1): check the exact `counter_h`/`counter_v` sequence over two full frames, including simultaneous H/V wrap.
